// File: rtl/ahbl_pkg.sv
// ahbl_pkg: AHB-Lite transfer/response encodings and
// the SRAM slave FSM state type.
package ahbl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam int unsigned WCNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_e;

  function automatic logic trans_active(
    input logic [1:0] t
  );
    return (t == HTRANS_NONSEQ) ||
           (t == HTRANS_SEQ);
  endfunction

  // 33-bit so an address below base wraps high
  function automatic logic [32:0] addr_offset(
    input logic [31:0] addr,
    input logic [31:0] base
  );
    return {1'b0, addr} - {1'b0, base};
  endfunction

endpackage

// File: rtl/ahbl_sram_array.sv
// ahbl_sram_array: word storage, one synchronous write
// port and one asynchronous read port, never reset.
module ahbl_sram_array #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/ahbl_sram_slave.sv
// ahbl_sram_slave: AHB-Lite word SRAM slave with
// configurable wait states and two-cycle ERROR response.
module ahbl_sram_slave
  import ahbl_pkg::*;
#(
  parameter int unsigned DEPTH       = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [32:0] LIMIT =
    33'(DEPTH * 4);
  localparam logic [WCNT_W-1:0] WAIT_CNT =
    WCNT_W'(WAIT_STATES);

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic              write_q, write_d;

  logic [32:0] off;
  logic        addr_ok;
  logic        start;
  logic        done;
  logic        accept;
  logic        data_done;
  logic        mem_we;
  logic        rd_en;
  logic [31:0] mem_rdata;

  assign off     = addr_offset(HADDR, BASE_ADDR);
  assign addr_ok = (off < LIMIT) &&
                   (HADDR[1:0] == 2'b00);
  assign start   = HSEL && HREADY &&
                   trans_active(HTRANS);

  assign data_done = (state_q == ST_WAIT) &&
                     (cnt_q == '0);
  assign done      = data_done ||
                     (state_q == ST_ERR2);
  assign accept    = start &&
                     ((state_q == ST_IDLE) || done);

  assign mem_we = data_done && write_q;
  assign rd_en  = data_done && !write_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      write_q <= write_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    write_d = write_q;
    unique case (state_q)
      ST_IDLE: ;
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = ST_IDLE;
    endcase
    // a new address phase overrides the return to idle
    if (accept) begin
      idx_d   = off[AW+1:2];
      write_d = HWRITE;
      if (addr_ok) begin
        state_d = ST_WAIT;
        cnt_d   = WAIT_CNT;
      end else begin
        state_d = ST_ERR1;
        cnt_d   = '0;
      end
    end
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    unique case (1'b1)
      state_q == ST_WAIT: begin
        HREADYOUT = (cnt_q == '0);
      end
      state_q == ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
      end
      state_q == ST_ERR2: begin
        HRESP = HRESP_ERROR;
      end
      default: ;
    endcase
  end

  assign HRDATA = rd_en ? mem_rdata : 32'h0;

  ahbl_sram_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (HCLK),
    .we    (mem_we),
    .waddr (idx_q),
    .wdata (HWDATA),
    .raddr (idx_q),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_ahbl_sram_slave.sv
// tb_ahbl_sram_slave: transaction-queue model of the slave,
// two DUTs (1 and 0 wait states) exercised in turn.
module tb_ahbl_sram_slave;
  import ahbl_pkg::*;

  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int          sel_dut = 0;
  logic        hsel = 1'b0;
  logic [31:0] haddr = 32'h0;
  logic [1:0]  htrans = HTRANS_IDLE;
  logic        hwrite = 1'b0;
  logic [31:0] hwdata = 32'h0;
  logic        hready_low = 1'b0;
  logic        hready;

  logic        rdy0, rsp0, rdy1, rsp1;
  logic [31:0] rd0, rd1;

  typedef enum {K_STALL, K_RD, K_WR, K_E1, K_E2} kind_e;
  typedef struct {
    kind_e k;
    int    idx;
  } ph_t;

  typedef struct packed {
    logic        sel;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        write;
    logic [31:0] data;
    logic        low;
  } op_t;

  ph_t         phq[$];
  op_t         opq[$];
  logic [31:0] mem_m [DEPTH];
  logic [31:0] pre [DEPTH];
  logic [33:0] exp_v = {2'b10, 32'h0};
  logic        acc_now = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int n_stall;
  int n_errc;
  logic [31:0] rd_seen[$];

  assign hready = exp_v[33] && !hready_low;

  ahbl_sram_slave #(
    .DEPTH(DEPTH), .BASE_ADDR(32'h0),
    .WAIT_STATES(1)
  ) u_ws1 (
    .HCLK(clk), .HRESETn(rst_n),
    .HSEL(hsel && sel_dut == 0),
    .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HWDATA(hwdata),
    .HREADY(hready), .HREADYOUT(rdy0),
    .HRESP(rsp0), .HRDATA(rd0)
  );

  ahbl_sram_slave #(
    .DEPTH(DEPTH), .BASE_ADDR(32'h0),
    .WAIT_STATES(0)
  ) u_ws0 (
    .HCLK(clk), .HRESETn(rst_n),
    .HSEL(hsel && sel_dut == 1),
    .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HWDATA(hwdata),
    .HREADY(hready), .HREADYOUT(rdy1),
    .HRESP(rsp1), .HRDATA(rd1)
  );

  task automatic chk(input string nm,
                     input logic [33:0] act,
                     input logic [33:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [33:0] bus0();
    return {rdy0, rsp0, rd0};
  endfunction

  function automatic logic [33:0] bus_sel();
    if (sel_dut == 1) return {rdy1, rsp1, rd1};
    return {rdy0, rsp0, rd0};
  endfunction

  function automatic logic [33:0] bus_other();
    if (sel_dut == 1) return {rdy0, rsp0, rd0};
    return {rdy1, rsp1, rd1};
  endfunction

  // expected outputs for the phase at the queue head
  function automatic logic [33:0] exp_of();
    if (phq.size() == 0) return {2'b10, 32'h0};
    case (phq[0].k)
      K_STALL: return {2'b00, 32'h0};
      K_RD:    return {2'b10, mem_m[phq[0].idx]};
      K_WR:    return {2'b10, 32'h0};
      K_E1:    return {2'b01, 32'h0};
      default: return {2'b11, 32'h0};
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    ph_t h;
    int  ws;
    if (!rst_n) begin
      phq.delete();
      acc_now <= 1'b0;
      exp_v   <= {2'b10, 32'h0};
    end else begin
      ws = (sel_dut == 0) ? 1 : 0;
      if (phq.size() > 0) begin
        h = phq.pop_front();
        if (h.k == K_WR) mem_m[h.idx] = hwdata;
      end
      if (hsel && hready && htrans[1]) begin
        acc_now <= 1'b1;
        if (haddr < 32'(DEPTH * 4) &&
            haddr[1:0] == 2'b00) begin
          for (int i = 0; i < ws; i++)
            phq.push_back('{K_STALL, 0});
          phq.push_back('{hwrite ? K_WR : K_RD,
                          int'(haddr >> 2)});
        end else begin
          phq.push_back('{K_E1, 0});
          phq.push_back('{K_E2, 0});
        end
      end else begin
        acc_now <= 1'b0;
      end
      exp_v <= exp_of();
    end
  end

  always @(negedge clk) begin : compare
    logic [33:0] a;
    a = bus_sel();
    chk("bus", a, exp_v);
    chk("idle_dut", bus_other(), {2'b10, 32'h0});
    if (!a[33]) n_stall++;
    if (a[32]) n_errc++;
    if (a[33] && a[31:0] != 32'h0)
      rd_seen.push_back(a[31:0]);
  end

  function automatic op_t mk(
    input logic sel, input logic [1:0] tr,
    input logic [31:0] a, input logic w,
    input logic [31:0] d, input logic lo);
    op_t o;
    o.sel = sel; o.trans = tr; o.addr = a;
    o.write = w; o.data = d; o.low = lo;
    return o;
  endfunction

  function automatic op_t rnd_op();
    op_t o;
    int  r;
    o.sel = ($urandom_range(0, 9) != 0);
    r = $urandom_range(0, 9);
    o.trans = r < 5 ? HTRANS_NONSEQ :
              r < 8 ? HTRANS_SEQ :
              r < 9 ? HTRANS_IDLE : HTRANS_BUSY;
    r = $urandom_range(0, 19);
    if (r == 0)
      o.addr = 32'(DEPTH * 4) +
               (32'($urandom_range(0, 255)) << 2);
    else if (r == 1)
      o.addr = (32'($urandom_range(0, DEPTH - 1)) << 2)
             | 32'($urandom_range(1, 3));
    else if (r == 2)
      o.addr = $urandom;
    else
      o.addr = 32'($urandom_range(0, DEPTH - 1)) << 2;
    o.write = 1'($urandom_range(0, 1));
    o.data  = $urandom;
    o.low   = 1'b0;
    return o;
  endfunction

  task automatic present(input op_t o);
    hsel = o.sel; htrans = o.trans; haddr = o.addr;
    hwrite = o.write; hready_low = o.low;
  endtask

  task automatic go_idle();
    hsel = 1'b0; htrans = HTRANS_IDLE;
    hready_low = 1'b0;
  endtask

  // pipelined master: next address during current data phase
  task automatic drive();
    int guard = 0;
    while (opq.size() > 0 || phq.size() > 0) begin
      if (opq.size() > 0) present(opq[0]);
      else go_idle();
      @(posedge clk); #1;
      guard++;
      if (guard > 20000) begin
        n_cmp++; n_bad++;
        $display("FAIL drive_timeout: got %0d want <%0d",
                 guard, 20000);
        break;
      end
      if (opq.size() > 0) begin
        if (acc_now) begin
          hwdata = opq[0].data;
          void'(opq.pop_front());
        end else if (!(opq[0].sel && opq[0].trans[1]
                       && !opq[0].low)) begin
          void'(opq.pop_front());
        end
      end
    end
    go_idle();
  endtask

  task automatic clear_mon();
    n_stall = 0; n_errc = 0; rd_seen.delete();
  endtask

  task automatic preload();
    for (int i = 0; i < DEPTH; i++) begin
      pre[i] = $urandom | 32'h1;
      if (i == 0) pre[i] = 32'h0BAD_F00D;
      opq.push_back(mk(1, HTRANS_NONSEQ,
                       32'(i) << 2, 1, pre[i], 0));
    end
    drive();
  endtask

  initial begin
    clear_mon();
    repeat (2) @(posedge clk);
    chk("reset_out", bus0(), {2'b10, 32'h0});
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    preload();

    clear_mon();
    opq.push_back(mk(1, HTRANS_NONSEQ, 32'h10, 1,
                     32'hDEAD_BEEF, 0));
    opq.push_back(mk(1, HTRANS_NONSEQ, 32'h10, 0,
                     32'h0, 0));
    drive();
    chk("ws1_stalls", 34'(n_stall), 34'd2);
    chk("ws1_errc", 34'(n_errc), 34'd0);
    chk("ws1_rdata", {2'b00, rd_seen[$]},
        {2'b00, 32'hDEAD_BEEF});

    clear_mon();
    opq.push_back(mk(1, HTRANS_NONSEQ, 32'h100, 0,
                     32'h0, 0));
    opq.push_back(mk(1, HTRANS_NONSEQ, 32'h02, 1,
                     32'h1234_5678, 0));
    opq.push_back(mk(1, HTRANS_NONSEQ, 32'h0, 0,
                     32'h0, 0));
    drive();
    chk("err_stalls", 34'(n_stall), 34'd3);
    chk("err_resp", 34'(n_errc), 34'd4);
    chk("err_mem0", {2'b00, rd_seen[$]},
        {2'b00, 32'h0BAD_F00D});

    clear_mon();
    opq.push_back(mk(1, HTRANS_BUSY, 32'h4, 1,
                     32'h5555_AAAA, 0));
    opq.push_back(mk(0, HTRANS_NONSEQ, 32'h4, 1,
                     32'h6666_BBBB, 0));
    drive();
    opq.push_back(mk(1, HTRANS_NONSEQ, 32'h4, 1,
                     32'h7777_CCCC, 1));
    opq.push_back(mk(1, HTRANS_NONSEQ, 32'h4, 0,
                     32'h0, 0));
    drive();
    chk("noxfer_stalls", 34'(n_stall), 34'd1);
    chk("noxfer_nreads", 34'(rd_seen.size()), 34'd1);
    chk("noxfer_mem1", {2'b00, rd_seen[$]},
        {2'b00, pre[1]});

    clear_mon();
    hsel = 1'b1; htrans = HTRANS_NONSEQ;
    haddr = 32'h20; hwrite = 1'b1;
    @(posedge clk); #1;
    go_idle();
    hwdata = 32'hCAFE_F00D;
    chk("wait_low", bus0(), {2'b00, 32'h0});
    #2 rst_n = 1'b0;
    #1 chk("rst_imm", bus0(), {2'b10, 32'h0});
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    opq.push_back(mk(1, HTRANS_NONSEQ, 32'h20, 0,
                     32'h0, 0));
    drive();
    chk("rst_nocommit", {2'b00, rd_seen[$]},
        {2'b00, pre[8]});

    for (int i = 0; i < 250; i++)
      opq.push_back(rnd_op());
    drive();

    sel_dut = 1;
    @(posedge clk); #1;
    preload();

    clear_mon();
    for (int i = 0; i < 3; i++)
      opq.push_back(mk(1, HTRANS_NONSEQ, 32'(i * 4),
                       1, 32'(i + 1), 0));
    for (int i = 0; i < 3; i++)
      opq.push_back(mk(1, i == 0 ? HTRANS_NONSEQ :
                       HTRANS_SEQ, 32'(i * 4), 0,
                       32'h0, 0));
    drive();
    chk("ws0_stalls", 34'(n_stall), 34'd0);
    chk("ws0_nreads", 34'(rd_seen.size()), 34'd3);
    for (int i = 0; i < 3; i++)
      chk("ws0_order", {2'b00, rd_seen[i]},
          {2'b00, 32'(i + 1)});

    for (int i = 0; i < 250; i++)
      opq.push_back(rnd_op());
    drive();

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ahbl_sram_slave.md
AHBL_SRAM_SLAVE -- requirements
Module: ahbl_sram_slave

Interface
REQ-001 SHALL have parameter DEPTH, 64, number of 32-bit words (power of 2, 4..1024).
REQ-002 SHALL have parameter BASE_ADDR, 32'h0000_0000, byte address of word 0 (aligned to 4*DEPTH).
REQ-003 SHALL have parameter WAIT_STATES, 1, wait cycles inserted per in-range transfer (0..7).
REQ-004 SHALL have port HCLK  in  1  single clock; all logic rising-edge.
REQ-005 SHALL have port HRESETn  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port HSEL  in  1  slave select.
REQ-007 SHALL have port HADDR  in  32  byte address (address phase).
REQ-008 SHALL have port HTRANS  in  2  transfer type (address phase).
REQ-009 SHALL have port HWRITE  in  1  1=write, 0=read (address phase).
REQ-010 SHALL have port HWDATA  in  32  write data (data phase).
REQ-011 SHALL have port HREADY  in  1  bus-level ready (previous transfer complete).
REQ-012 SHALL have port HREADYOUT  out  1  this slave's ready.
REQ-013 SHALL have port HRESP  out  1  0=OKAY, 1=ERROR.
REQ-014 SHALL have port HRDATA  out  32  read data (data phase).

Function
REQ-015 Transfer SHALL be accepted on an edge where HSEL=1, HREADY=1, HTRANS[1]=1 (NONSEQ/SEQ); all transfers are word-size.
REQ-016 On acceptance SHALL latch HADDR and HWRITE; index = (HADDR-BASE_ADDR)>>2.
REQ-017 Transfer SHALL be invalid if HADDR<BASE_ADDR, HADDR>=BASE_ADDR+4*DEPTH, or HADDR[1:0]!=0.
REQ-018 FSM states SHALL be IDLE, WAIT, ERR1, ERR2; accept from IDLE, or from the completing cycle of WAIT/ERR2 (pipelined back-to-back).
REQ-019 Valid accept with WAIT_STATES>0 -> WAIT: HREADYOUT=0 for WAIT_STATES cycles (down-counter), then one cycle HREADYOUT=1, HRESP=0.
REQ-020 Valid accept with WAIT_STATES=0 -> data phase completes in the first cycle after acceptance, HREADYOUT=1.
REQ-021 Write SHALL commit HWDATA to mem[index] at the edge ending the completing data-phase cycle; no earlier.
REQ-022 Read SHALL drive mem[index] on HRDATA during the completing cycle; a read directly after a write to the same word SHALL return the new data.
REQ-023 Invalid accept -> ERR1 (HREADYOUT=0, HRESP=1) -> ERR2 (HREADYOUT=1, HRESP=1) -> IDLE; memory unmodified; no wait states applied.
REQ-024 IDLE/BUSY HTRANS, HSEL=0, or HREADY=0 SHALL not start a transfer; slave presents HREADYOUT=1, HRESP=0 (zero-wait OKAY).
REQ-025 HRDATA SHALL be 0 outside a completing read cycle.
REQ-026 HREADY=0 while this slave is idle (other slave stalling) SHALL not advance or alter state.

Reset
REQ-027 HRESETn=0 SHALL immediately force IDLE, wait counter 0, HREADYOUT=1, HRESP=0, HRDATA=0.
REQ-028 Reset mid-WAIT or mid-ERR SHALL abandon the transfer; a pending write SHALL not commit.
REQ-029 Memory contents SHALL not be reset (undefined at power-up, retained across reset).

Structure
REQ-030 Shared package ahbl_pkg SHALL hold HTRANS encodings (IDLE 2'b00, BUSY 2'b01, NONSEQ 2'b10, SEQ 2'b11), HRESP OKAY/ERROR constants, FSM state typedef.
REQ-031 Storage SHALL be a sub-module ahbl_sram_array (1 write port, 1 async-read port, no reset); FSM/decode in top.

Verification
REQ-032 WAIT_STATES=1: write 32'hDEADBEEF @0x10, read @0x10 -> one HREADYOUT=0 cycle each, HRDATA=32'hDEADBEEF, HRESP=0.
REQ-033 WAIT_STATES=0: pipelined NONSEQ writes 0x0,0x4,0x8 then reads -> no stall, data 1,2,3 returned in order.
REQ-034 DEPTH=64: read @0x100 and write @0x02 -> each exactly ERR1,ERR2 (HREADYOUT 0 then 1, HRESP=1 both); mem[0] unchanged.
REQ-035 HRESETn pulsed during WAIT of a write @0x20 -> outputs reset values immediately; subsequent read @0x20 returns prior value.
REQ-036 HTRANS=BUSY and HSEL=0 with HADDR=0x4, HWRITE=1 -> HREADYOUT=1, HRESP=0, mem[1] unchanged.
